// File: rtl/piso_pkg.sv
// Shared constants and the word-length derivation for piso_serializer.
// Defining PISO_SERIALIZER_PARITY_EN adds one trailing even-parity bit to each word.
`ifndef PISO_PKG_SV
`define PISO_PKG_SV

`ifdef PISO_SERIALIZER_PARITY_EN
`define PISO_NBITS(W) ((W) + 1)
`else
`define PISO_NBITS(W) (W)
`endif

package piso_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

   localparam logic SER_IDLE_LEVEL = 1'b0;

   // Serial cycles per word, including the parity bit when it is built in.
   function automatic int calc_nbits(input int width);
      return `PISO_NBITS(width);
   endfunction

   function automatic int calc_cw(input int nbits);
      return (nbits > 2) ? $clog2(nbits) : 1;
   endfunction

endpackage

`endif

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: one WIDTH-bit word in over valid/ready, one bit per clk out.
// Build with PISO_SERIALIZER_PARITY_EN to append an even-parity bit after the data bits.
module piso_serializer
   import piso_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             areset,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             last_bit
);

   localparam int              NBITS    = calc_nbits(WIDTH);
   localparam int              CW       = calc_cw(NBITS);
   localparam logic [CW-1:0]   CNT_LOAD = CW'(NBITS - 1);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

   state_e           r_state;
   logic [WIDTH-1:0] r_shift;
   logic [CW-1:0]    r_cnt;

   logic             w_accept;
   logic             w_din_first;
   logic [WIDTH-1:0] w_load_shift;
   logic             w_step_bit;
   logic [WIDTH-1:0] w_step_shift;
   logic             w_step_out;

   // last_bit is registered, so ready never looks at din_valid.
   assign din_ready = (r_state == ST_IDLE) || (r_state == ST_SHIFT && last_bit);
   assign w_accept  = din_valid && din_ready;

   // The register holds only the bits still to be sent, with the next one at the output end.
   generate
      if (MSB_FIRST) begin : g_msb
         assign w_din_first  = din[WIDTH-1];
         assign w_load_shift = {din[WIDTH-2:0], 1'b0};
         assign w_step_bit   = r_shift[WIDTH-1];
         assign w_step_shift = {r_shift[WIDTH-2:0], 1'b0};
      end else begin : g_lsb
         assign w_din_first  = din[0];
         assign w_load_shift = {1'b0, din[WIDTH-1:1]};
         assign w_step_bit   = r_shift[0];
         assign w_step_shift = {1'b0, r_shift[WIDTH-1:1]};
      end
   endgenerate

`ifdef PISO_SERIALIZER_PARITY_EN
   logic r_par;

   always_ff @(posedge clk) begin
      if (areset)
         r_par <= 1'b0;
      else if (w_accept)
         r_par <= ^din;
   end

   assign w_step_out = (r_cnt == CNT_ONE) ? r_par : w_step_bit;
`else
   assign w_step_out = w_step_bit;
`endif

   // Accept is only possible in IDLE or on the last bit, so it takes precedence over stepping.
   always_ff @(posedge clk) begin
      if (areset) begin
         r_state   <= ST_IDLE;
         r_shift   <= '0;
         r_cnt     <= '0;
         ser_out   <= SER_IDLE_LEVEL;
         ser_valid <= 1'b0;
         last_bit  <= 1'b0;
      end else if (w_accept) begin
         r_state   <= ST_SHIFT;
         r_shift   <= w_load_shift;
         r_cnt     <= CNT_LOAD;
         ser_out   <= w_din_first;
         ser_valid <= 1'b1;
         last_bit  <= 1'b0;
      end else if (r_state == ST_SHIFT && r_cnt != '0) begin
         r_shift   <= w_step_shift;
         r_cnt     <= r_cnt - CNT_ONE;
         ser_out   <= w_step_out;
         last_bit  <= (r_cnt == CNT_ONE);
      end else begin
         r_state   <= ST_IDLE;
         r_shift   <= '0;
         r_cnt     <= '0;
         ser_out   <= SER_IDLE_LEVEL;
         ser_valid <= 1'b0;
         last_bit  <= 1'b0;
      end
   end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in/serial-out stage that sits directly upstream of the serial 1010 pattern detector and drives its data_in.
- Accepts a WIDTH-bit word over a valid/ready handshake.
- Shifts the word out one bit per clk cycle.
- Back-to-back words form a gapless bit stream, so the detector sees contiguous patterns across word boundaries.

Parameters:
WIDTH, 8, bits per parallel word (legal range 2..32)
MSB_FIRST, 1, 1 = din[WIDTH-1] is sent first; 0 = din[0] is sent first

Ports:
clk  input  1  rising-edge clock, single clock domain
areset  input  1  synchronous active-high reset, sampled on the rising edge of clk
din  input  WIDTH  parallel word, sampled only on an accepted handshake
din_valid  input  1  upstream has a word on din
din_ready  output  1  block can take a word this cycle (combinational)
ser_out  output  1  serial bit stream, registered; connects to detector data_in
ser_valid  output  1  high while ser_out carries a payload (or parity) bit
last_bit  output  1  high while ser_out carries the final bit of the current word

Behaviour:
- Reset (areset=1 at posedge clk):
  - state=IDLE; shift register, bit counter, ser_out, ser_valid and last_bit all 0.
  - din_ready=1 from the following cycle.
  - Reset has priority over everything, including an active handshake that same edge.
- States: IDLE, SHIFT.
- Handshake: a word is accepted at a posedge where din_valid && din_ready && !areset.
- din_ready = (state==IDLE) || (state==SHIFT && last_bit).
  - It does not depend on din_valid, so there is no combinational loop.
- Latency: the first bit of an accepted word appears on ser_out in the cycle right after the accepting edge.
  - Each bit is held exactly one cycle.
  - A word occupies NBITS consecutive cycles: NBITS = WIDTH, or WIDTH+1 when the parity feature is enabled.
- IDLE → SHIFT on accept:
  - Load the shift register with din.
  - ser_out = first bit; ser_valid=1.
  - Bit counter = NBITS-1.
- SHIFT, counter > 0:
  - Shift toward the output end, filling with 0.
  - ser_out = next bit; counter decrements.
  - last_bit=1 when the counter reaches 0.
- SHIFT, counter == 0 (last bit on the line):
  - If a word is accepted: reload and stay in SHIFT, with no idle cycle between words.
  - Otherwise: go to IDLE; ser_out=0, ser_valid=0, last_bit=0.
- In IDLE, ser_out is driven 0. This flushes the downstream detector toward its idle state.
- din_valid while din_ready=0:
  - The word is not taken and din is ignored.
  - Upstream must hold din and din_valid stable until accepted.
- Reset mid-word:
  - The word is discarded without completion.
  - ser_out=0 on the cycle after the reset edge.
  - No partial word is resumed.
- Bit counter width: $clog2(NBITS) bits, minimum 1. It never wraps below 0.

Optional Feature:
Macro: PISO_SERIALIZER_PARITY_EN
- Defined:
  - One extra bit is appended after the last data bit: even parity, the XOR of all WIDTH data bits, computed at load time and stored in a register.
  - NBITS = WIDTH+1. last_bit asserts on the parity bit.
  - din_ready reopens on the parity cycle.
- Undefined:
  - No parity register and no extra cycle; NBITS = WIDTH.

Decomposition:
- Shared package/header piso_pkg holds:
  - state encoding constants ST_IDLE=1'b0 and ST_SHIFT=1'b1;
  - the idle line level constant SER_IDLE_LEVEL=1'b0;
  - the NBITS derivation macro.
- No sub-module; a single module is natural. The shift register, counter and two-state FSM are all tightly coupled.

Test Plan:
- Basic word: WIDTH=8, MSB_FIRST=1, reset, then one handshake with din=8'hA0.
  - ser_out over the next 8 cycles = 1,0,1,0,0,0,0,0.
  - ser_valid=1 for exactly those 8 cycles; last_bit=1 on cycle 8.
  - ser_out=0 afterwards; the downstream detector output goes high once, after the 4th bit.
- Back-to-back: din_valid held high with 8'hAA, then 8'h55.
  - 16 contiguous bits 10101010 01010101 with no gap.
  - din_ready=1 only in IDLE and on each last_bit cycle; ser_valid never drops between the words.
- Backpressure: raise din_valid with 8'hFF two cycles after the first word starts.
  - Not accepted until the last_bit cycle of the first word.
  - The second word starts immediately after, with no bits lost or duplicated.
- Reset mid-word: assert areset for one cycle on bit 3 of 8'hF0.
  - ser_out=0, ser_valid=0 and din_ready=1 on the next cycle; the remaining bits are never emitted.
- LSB-first: MSB_FIRST=0, din=8'h05 → ser_out = 1,0,1,0,0,0,0,0.
- Parity (macro defined): din=8'h07 → 8 data bits 0,0,0,0,0,1,1,1, then parity bit 1.
  - last_bit on cycle 9.
  - din=8'h03 gives parity 0.
